// File: rtl/riscv_mem_pkg.sv
// Shared types and decode helpers for the RV64 memory-access stage.
package riscv_mem_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mstate_t;

  function automatic logic is_load(mem_op_t op);
    case (op)
      LB, LH, LW, LD, LBU, LHU, LWU: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(mem_op_t op);
    case (op)
      SB, SH, SW, SD: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  // log2 of the access size in bytes: 0=byte, 1=half, 2=word, 3=double
  function automatic logic [1:0] access_size(mem_op_t op);
    case (op)
      LB, LBU, SB: return 2'd0;
      LH, LHU, SH: return 2'd1;
      LW, LWU, SW: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [2:0] a);
    case (access_size(op))
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(mem_op_t op, logic [2:0] a);
    logic [7:0] m;
    case (access_size(op))
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << a;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-cache port between the memory stage (master) and the cache (slave).
// A request transfers on a cycle with dc_req_valid && dc_req_ready; once raised,
// valid and every request field hold until that cycle. dc_resp_valid is a
// one-cycle pulse with no back-pressure.
interface memory_stage_if #(
  parameter int XLEN = 64
) ();
  logic            dc_req_valid;
  logic            dc_req_ready;
  logic [XLEN-1:0] dc_req_addr;
  logic            dc_req_write;
  logic [XLEN-1:0] dc_req_wdata;
  logic [7:0]      dc_req_wstrb;
  logic            dc_resp_valid;
  logic [XLEN-1:0] dc_resp_rdata;

  modport master (
    output dc_req_valid, dc_req_addr, dc_req_write, dc_req_wdata, dc_req_wstrb,
    input  dc_req_ready, dc_resp_valid, dc_resp_rdata
  );

  modport slave (
    input  dc_req_valid, dc_req_addr, dc_req_write, dc_req_wdata, dc_req_wstrb,
    output dc_req_ready, dc_resp_valid, dc_resp_rdata
  );
endinterface

// File: rtl/memory_stage_load_align.sv
// Extracts the addressed bytes from a raw doubleword and sign/zero-extends them.
module load_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  mem_op_t         op,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    data    = shifted;
    case (op)
      LB:      data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      LH:      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LW:      data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LBU:     data = {{(XLEN-8){1'b0}},         shifted[7:0]};
      LHU:     data = {{(XLEN-16){1'b0}},        shifted[15:0]};
      LWU:     data = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: data = shifted;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// RV64 memory-access stage: issues loads/stores to the data cache, aligns load
// data and emits one registered writeback record per instruction.
module memory_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  mem_op_t           ex_op,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [XLEN-1:0]   ex_pc,
  memory_stage_if.master    dc,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_misaligned,
  output logic [XLEN-1:0]   exc_pc,
  output mstate_t           state_dbg
);
  mstate_t          state, state_n;
  mem_op_t          op_q;
  logic [REG_W-1:0] rd_q;
  logic [2:0]       off_q;

  logic             req_valid_q;
  logic [XLEN-1:0]  req_addr_q;
  logic             req_write_q;
  logic [XLEN-1:0]  req_wdata_q;
  logic [7:0]       req_wstrb_q;

  logic             accept, is_mem, mis, go_mem, go_alu, req_fire, resp_fire;
  logic [XLEN-1:0]  load_data;

  assign ex_ready  = (state == IDLE);
  assign state_dbg = state;

  assign dc.dc_req_valid = req_valid_q;
  assign dc.dc_req_addr  = req_addr_q;
  assign dc.dc_req_write = req_write_q;
  assign dc.dc_req_wdata = req_wdata_q;
  assign dc.dc_req_wstrb = req_wstrb_q;

  always_comb begin
    accept    = ex_valid && ex_ready;
    is_mem    = is_load(ex_op) || is_store(ex_op);
    mis       = accept && is_mem && is_misaligned(ex_op, ex_result[2:0]);
    go_mem    = accept && is_mem && !mis;
    go_alu    = accept && !is_mem;
    req_fire  = (state == REQ) && req_valid_q && dc.dc_req_ready;
    resp_fire = (state == WAIT) && dc.dc_resp_valid;

    state_n = state;
    case (state)
      IDLE:    if (go_mem) state_n = REQ;
      REQ:     if (req_fire) state_n = is_store(op_q) ? IDLE : WAIT;
      WAIT:    if (dc.dc_resp_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .op     (op_q),
    .offset (off_q),
    .rdata  (dc.dc_resp_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= NONE;
      rd_q           <= '0;
      off_q          <= '0;
      req_valid_q    <= 1'b0;
      req_addr_q     <= '0;
      req_write_q    <= 1'b0;
      req_wdata_q    <= '0;
      req_wstrb_q    <= '0;
      wb_valid       <= 1'b0;
      wb_we          <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      exc_misaligned <= 1'b0;
      exc_pc         <= '0;
    end else begin
      state          <= state_n;
      wb_valid       <= 1'b0;
      wb_we          <= 1'b0;
      exc_misaligned <= 1'b0;

      if (go_alu) begin
        wb_valid <= 1'b1;
        wb_we    <= (ex_rd != '0);
        wb_rd    <= ex_rd;
        wb_data  <= ex_result;
      end

      if (mis) begin
        exc_misaligned <= 1'b1;
        exc_pc         <= ex_pc;
        wb_valid       <= 1'b1;
        wb_rd          <= ex_rd;
      end

      // Request fields are captured once here and stay frozen until the handshake.
      if (go_mem) begin
        op_q        <= ex_op;
        rd_q        <= ex_rd;
        off_q       <= ex_result[2:0];
        req_valid_q <= 1'b1;
        req_addr_q  <= {ex_result[XLEN-1:3], 3'b000};
        req_write_q <= is_store(ex_op);
        req_wdata_q <= is_store(ex_op) ? (ex_store_data << {ex_result[2:0], 3'b000}) : '0;
        req_wstrb_q <= is_store(ex_op) ? lane_mask(ex_op, ex_result[2:0]) : 8'h00;
      end

      if (req_fire) begin
        req_valid_q <= 1'b0;
        if (is_store(op_q)) begin
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
        end
      end

      if (resp_fire) begin
        wb_valid <= 1'b1;
        wb_we    <= (rd_q != '0);
        wb_rd    <= rd_q;
        wb_data  <= load_data;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage with a writeback scoreboard.
module tb_memory_stage;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  mem_op_t     ex_op;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result, ex_store_data, ex_pc;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        exc_misaligned;
  logic [63:0] exc_pc;
  mstate_t     state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // {we, rd, data}; rd and data are compared only for records that write
  logic [69:0] exp_q[$];

  memory_stage_if #(.XLEN(64)) dc_if ();

  memory_stage #(.XLEN(64), .REG_W(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_op          (ex_op),
    .ex_rd          (ex_rd),
    .ex_result      (ex_result),
    .ex_store_data  (ex_store_data),
    .ex_pc          (ex_pc),
    .dc             (dc_if.master),
    .wb_valid       (wb_valid),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .exc_misaligned (exc_misaligned),
    .exc_pc         (exc_pc),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every writeback pulse must match the next expected record
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 64'(wb_valid), 64'd0);
      end else begin
        logic [69:0] e;
        e = exp_q.pop_front();
        check("wb_we", 64'(wb_we), 64'(e[69]));
        if (e[69]) begin
          check("wb_rd", 64'(wb_rd), 64'(e[68:64]));
          check("wb_data", wb_data, e[63:0]);
        end
      end
    end
  end

  // drivers
  task automatic issue(input mem_op_t op, input logic [4:0] rd, input logic [63:0] res,
                       input logic [63:0] sd, input logic [63:0] pc);
    check("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_op = op; ex_rd = rd; ex_result = res; ex_store_data = sd; ex_pc = pc;
    tick();
    ex_valid = 1'b0; ex_op = NONE; ex_result = {$urandom, $urandom};
  endtask

  task automatic run_mem(input mem_op_t op, input logic [4:0] rd, input logic [63:0] addr,
                         input logic [63:0] sdata, input int delay, input logic [63:0] exp_addr,
                         input logic exp_write, input logic [7:0] exp_wstrb,
                         input logic [63:0] exp_wdata, input logic [63:0] rdata);
    issue(op, rd, addr, sdata, 64'h8000_0000 + addr);
    for (int i = 0; i <= delay; i++) begin
      check("req_valid", 64'(dc_if.dc_req_valid), 64'd1);
      check("req_addr", dc_if.dc_req_addr, exp_addr);
      check("req_write", 64'(dc_if.dc_req_write), 64'(exp_write));
      if (exp_write) begin
        check("req_wstrb", 64'(dc_if.dc_req_wstrb), 64'(exp_wstrb));
        check("req_wdata", dc_if.dc_req_wdata, exp_wdata);
      end
      check("ex_ready_busy", 64'(ex_ready), 64'd0);
      if (i == delay) dc_if.dc_req_ready = 1'b1;
      tick();
    end
    dc_if.dc_req_ready = 1'b0;
    check("req_drop", 64'(dc_if.dc_req_valid), 64'd0);
    if (!exp_write) begin
      check("ex_ready_wait", 64'(ex_ready), 64'd0);
      dc_if.dc_resp_valid = 1'b1;
      dc_if.dc_resp_rdata = rdata;
      tick();
      dc_if.dc_resp_valid = 1'b0;
      dc_if.dc_resp_rdata = {$urandom, $urandom};
    end
    check("ex_ready_done", 64'(ex_ready), 64'd1);
    check("wb_pulse", 64'(wb_valid), 64'd1);
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_op = NONE; ex_rd = '0;
    ex_result = '0; ex_store_data = '0; ex_pc = '0;
    dc_if.dc_req_ready = 1'b0; dc_if.dc_resp_valid = 1'b0; dc_if.dc_resp_rdata = '0;
    repeat (3) tick();

    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_req_valid", 64'(dc_if.dc_req_valid), 64'd0);
    check("rst_req_write", 64'(dc_if.dc_req_write), 64'd0);
    check("rst_req_addr", dc_if.dc_req_addr, 64'd0);
    check("rst_req_wdata", dc_if.dc_req_wdata, 64'd0);
    check("rst_req_wstrb", 64'(dc_if.dc_req_wstrb), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_we", 64'(wb_we), 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_exc", 64'(exc_misaligned), 64'd0);
    check("rst_exc_pc", exc_pc, 64'd0);
    reset = 1'b0;
    tick();

    // non-memory ops back to back
    ex_valid = 1'b1; ex_op = NONE; ex_rd = 5'd5; ex_result = 64'h1234; ex_pc = 64'h100;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 5'd5, 64'h1234});
      check("alu_ex_ready", 64'(ex_ready), 64'd1);
      tick();
      check("alu_wb_valid", 64'(wb_valid), 64'd1);
    end
    ex_valid = 1'b0;
    tick();
    check("alu_pulse_end", 64'(wb_valid), 64'd0);

    // loads: sign and zero extension at various offsets
    exp_q.push_back({1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80});
    run_mem(LB, 5'd7, 64'h1003, 64'd0, 0, 64'h1000, 1'b0, 8'h00, 64'd0, 64'h0000_0000_8000_0000);
    exp_q.push_back({1'b1, 5'd8, 64'h0000_0000_0000_0080});
    run_mem(LBU, 5'd8, 64'h1003, 64'd0, 0, 64'h1000, 1'b0, 8'h00, 64'd0, 64'h0000_0000_8000_0000);
    exp_q.push_back({1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_8001});
    run_mem(LH, 5'd10, 64'h1006, 64'd0, 1, 64'h1000, 1'b0, 8'h00, 64'd0, 64'h8001_0000_0000_0000);
    exp_q.push_back({1'b1, 5'd11, 64'h0000_0000_0000_8001});
    run_mem(LHU, 5'd11, 64'h1006, 64'd0, 0, 64'h1000, 1'b0, 8'h00, 64'd0, 64'h8001_0000_0000_0000);
    exp_q.push_back({1'b1, 5'd12, 64'hFFFF_FFFF_F000_0000});
    run_mem(LW, 5'd12, 64'h2FFC, 64'd0, 0, 64'h2FF8, 1'b0, 8'h00, 64'd0, 64'hF000_0000_1234_5678);
    exp_q.push_back({1'b1, 5'd13, 64'h0000_0000_F000_0000});
    run_mem(LWU, 5'd13, 64'h2FFC, 64'd0, 0, 64'h2FF8, 1'b0, 8'h00, 64'd0, 64'hF000_0000_1234_5678);
    exp_q.push_back({1'b1, 5'd14, 64'h0123_4567_89AB_CDEF});
    run_mem(LD, 5'd14, 64'h4008, 64'd0, 2, 64'h4008, 1'b0, 8'h00, 64'd0, 64'h0123_4567_89AB_CDEF);

    // load to x0 never writes
    exp_q.push_back({1'b0, 5'd0, 64'd0});
    run_mem(LD, 5'd0, 64'h5000, 64'd0, 0, 64'h5000, 1'b0, 8'h00, 64'd0, 64'h0000_0000_DEAD_BEEF);

    // stores: lane placement and a stalled handshake
    exp_q.push_back({1'b0, 5'd0, 64'd0});
    run_mem(SH, 5'd0, 64'h2006, 64'hABCD, 3, 64'h2000, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000, 64'd0);
    exp_q.push_back({1'b0, 5'd0, 64'd0});
    run_mem(SB, 5'd0, 64'h7005, 64'hAA, 0, 64'h7000, 1'b1, 8'h20, 64'h0000_AA00_0000_0000, 64'd0);
    exp_q.push_back({1'b0, 5'd0, 64'd0});
    run_mem(SW, 5'd0, 64'h7004, 64'h1122_3344_5566_7788, 1, 64'h7000, 1'b1, 8'hF0,
            64'h5566_7788_0000_0000, 64'd0);
    exp_q.push_back({1'b0, 5'd0, 64'd0});
    run_mem(SD, 5'd0, 64'h6000, 64'h1122_3344_5566_7788, 0, 64'h6000, 1'b1, 8'hFF,
            64'h1122_3344_5566_7788, 64'd0);

    // misaligned accesses raise a one-cycle exception and skip the cache
    exp_q.push_back({1'b0, 5'd9, 64'd0});
    issue(LW, 5'd9, 64'h3002, 64'd0, 64'h4000_0010);
    check("mis_exc", 64'(exc_misaligned), 64'd1);
    check("mis_exc_pc", exc_pc, 64'h4000_0010);
    check("mis_no_req", 64'(dc_if.dc_req_valid), 64'd0);
    check("mis_wb_valid", 64'(wb_valid), 64'd1);
    check("mis_wb_we", 64'(wb_we), 64'd0);
    tick();
    check("mis_exc_pulse", 64'(exc_misaligned), 64'd0);
    check("mis_no_req2", 64'(dc_if.dc_req_valid), 64'd0);
    exp_q.push_back({1'b0, 5'd2, 64'd0});
    issue(SD, 5'd2, 64'h6004, 64'h55, 64'h4000_0020);
    check("mis_sd_exc", 64'(exc_misaligned), 64'd1);
    check("mis_sd_exc_pc", exc_pc, 64'h4000_0020);
    check("mis_sd_no_req", 64'(dc_if.dc_req_valid), 64'd0);
    tick();

    // stray response while idle is ignored
    dc_if.dc_resp_valid = 1'b1;
    tick();
    dc_if.dc_resp_valid = 1'b0;
    tick();
    check("stray_no_wb", 64'(wb_valid), 64'd0);
    check("stray_idle", 64'(state_dbg), 64'(IDLE));

    // reset while waiting for load data drops the access
    issue(LD, 5'd4, 64'h8000, 64'd0, 64'h4000_0030);
    check("rw_req", 64'(dc_if.dc_req_valid), 64'd1);
    dc_if.dc_req_ready = 1'b1;
    tick();
    dc_if.dc_req_ready = 1'b0;
    check("rw_state_wait", 64'(state_dbg), 64'(WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_ex_ready", 64'(ex_ready), 64'd1);
    check("rw_req_clear", 64'(dc_if.dc_req_valid), 64'd0);
    dc_if.dc_resp_valid = 1'b1;
    dc_if.dc_resp_rdata = 64'h1111_2222_3333_4444;
    tick();
    dc_if.dc_resp_valid = 1'b0;
    check("rw_no_wb", 64'(wb_valid), 64'd0);
    check("rw_idle", 64'(state_dbg), 64'(IDLE));
    exp_q.push_back({1'b1, 5'd3, 64'h55});
    issue(NONE, 5'd3, 64'h55, 64'd0, 64'h4000_0040);
    check("rw_next_wb", 64'(wb_valid), 64'd1);

    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Memory-access stage of the in-order RV64 pipeline. Sits directly downstream of execute and upstream of writeback. Takes the execute result (ALU value or effective address), performs loads and stores through a valid/ready data-cache port, aligns and extends load data, and presents one registered writeback record per instruction. Back-pressures execute while a cache access is outstanding.

## Interface
Parameters:
- XLEN, 64, datapath and address width
- REG_W, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage accepts an instruction this cycle
- ex_op  in  4  mem_op_t: NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
- ex_rd  in  REG_W  destination register
- ex_result  in  XLEN  ALU result; effective address for memory ops
- ex_store_data  in  XLEN  rs2 value for stores
- ex_pc  in  XLEN  instruction PC
- dc_req_valid  out  1  cache request valid
- dc_req_ready  in  1  cache accepts request
- dc_req_addr  out  XLEN  doubleword-aligned address (addr[2:0]=0)
- dc_req_write  out  1  1 = store
- dc_req_wdata  out  XLEN  store data shifted into byte lanes
- dc_req_wstrb  out  8  byte-lane enables
- dc_resp_valid  in  1  load data valid (one cycle, no ready)
- dc_resp_rdata  in  XLEN  raw doubleword
- wb_valid  out  1  writeback record valid (one-cycle pulse)
- wb_we  out  1  register write enable
- wb_rd  out  REG_W  destination register
- wb_data  out  XLEN  write data
- exc_misaligned  out  1  misaligned-access exception pulse
- exc_pc  out  XLEN  PC of faulting instruction

## Operation
- FSM states IDLE, REQ, WAIT. ex_ready = (state == IDLE).
- IDLE, ex_valid=1:
  - op NONE: next cycle wb_valid=1, wb_data=ex_result, wb_rd=ex_rd; stay IDLE.
  - Misaligned memory op (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0): next cycle exc_misaligned=1, exc_pc=ex_pc, wb_valid=1 with wb_we=0; no cache request; stay IDLE.
  - Otherwise latch op, rd, addr, pc, store data; go REQ.
- REQ: dc_req_valid=1; request fields held stable until dc_req_ready. On handshake: store → wb_valid=1, wb_we=0 next cycle, go IDLE; load → go WAIT.
- WAIT: on dc_resp_valid, extract bytes at addr[2:0], sign-extend (LB/LH/LW/LD) or zero-extend (LBU/LHU/LWU); next cycle wb_valid=1, wb_we=1, wb_data=result; go IDLE.
- Store lanes: SB wstrb=1<<a, SH 3<<a, SW 0xF<<a, SD 0xFF (a=addr[2:0]); wdata = store_data << (8·a).
- wb_we forced 0 whenever rd=0.
- dc_resp_valid outside WAIT is ignored.
- reset: state→IDLE, outstanding access dropped, in-flight response after reset ignored.

## Timing
- Reset values: ex_ready=1 (IDLE), dc_req_valid=0, dc_req_write=0, dc_req_addr/wdata/wstrb=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, exc_misaligned=0, exc_pc=0.
- All outputs except ex_ready registered.
- Non-memory op: latency 1; back-to-back every cycle.
- Load accepted cycle T: dc_req_valid at T+1; handshake at earliest T+1; response earliest T+2; wb_valid at T+3.
- Store accepted at T, ready at T+1 → wb_valid at T+2.
- wb_valid and exc_misaligned are single-cycle pulses.
- dc_req_valid never deasserts before handshake (except reset).

## Structure
- Package riscv_mem_pkg: mem_op_t enum, mstate_t enum, helpers is_load/is_store/access_size.
- Sub-module load_align: combinational extract and sign/zero-extend of dc_resp_rdata by op and addr[2:0].

## Test plan
- ex_op=NONE, ex_result=0x1234, rd=5, three consecutive cycles → three wb_valid pulses, wb_data=0x1234, ex_ready held 1.
- LB addr=0x1003, rdata=0x00000000_80000000 → dc_req_addr=0x1000, wb_data=0xFFFFFFFF_FFFFFF80; LBU same → 0x80.
- SH addr=0x2006, store_data=0xABCD, dc_req_ready delayed 3 cycles → request stable, wstrb=0xC0, wdata=0xABCD<<48, ex_ready=0 until handshake.
- LW addr=0x3002 → exc_misaligned=1, exc_pc=ex_pc, no dc_req_valid, wb_we=0.
- LD rd=0, rdata=0xDEADBEEF → wb_valid=1, wb_we=0.
- reset asserted in WAIT, dc_resp_valid arrives next cycle → IDLE, no wb_valid, next op handled normally.
